// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding and bus defaults for the data-memory responder
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  localparam int BUS_ADDR_W = 8;
  localparam int BUS_DATA_W = 8;
  localparam logic [7:0] DEF_BASE = 8'hE0;
  localparam int DEF_WAIT_STATES = 1;
endpackage

// File: rtl/mem_bus_responder_ram.sv
// resp_ram: single-port synchronous write-first RAM, accessed only when en is high
module resp_ram #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= we ? wdata : mem[addr];
    end
  end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: data-memory bus target with wait states, RAM window and out-of-window error
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int MEM_AW = 5,
  parameter logic [ADDR_W-1:0] BASE = ADDR_W'(DEF_BASE),
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);
  state_t state;
  logic [3:0] cnt;
  logic we_q, hit_q, hit, done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ram_q;
  assign hit  = addr_q[ADDR_W-1:MEM_AW] == BASE[ADDR_W-1:MEM_AW];
  assign done = (state == BUSY) && (cnt == 4'd0);
  // ram_q and hit_q only change on the completion edge, so rdata is zero after reset and on a miss
  assign rdata = hit_q ? ram_q : '0;
  resp_ram #(.AW(MEM_AW), .DW(DATA_W)) u_ram (
    .clk  (clk),
    .en   (done && hit),
    .we   (we_q),
    .addr (addr_q[MEM_AW-1:0]),
    .wdata(wdata_q),
    .rdata(ram_q)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable && req) begin
          we_q    <= we;
          addr_q  <= addr;
          wdata_q <= wdata;
          cnt     <= 4'(WAIT_STATES);
          busy    <= 1'b1;
          state   <= BUSY;
        end
        BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          ack   <= 1'b1;
          err   <= !hit;
          hit_q <= hit;
          state <= RESP;
        end
        RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
